wb_uart_loader: RTL and testbench

- Wishbone classic initiator that turns a UART receive byte stream into single-word write cycles.
- Loads a program image into the on-chip RAM responder: header gives start address and word count, payload words are written in order.
- Sits between the UART receiver byte interface and the RAM Wishbone port, muxed ahead of the core during boot.
- Reports completion and bus timeout to the SoC.

---
 rtl/wb_uart_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_wb_uart_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_loader.sv
// Purpose: UART byte stream -> Wishbone classic single-word writes (boot image loader).
// Latency: write cycle starts the edge the 4th payload byte is consumed; next byte accepted the cycle after ack.
// Backpressure: rx_ready low for the whole bus cycle; offered bytes are held upstream until rx_ready returns.
// Ports: clk/reset (sync, active-high); rx_data/rx_valid/rx_ready byte input;
//        wb_* Wishbone classic initiator; busy/done/error/entry status to the SoC.
module wb_uart_loader #(
    parameter logic [7:0] MAGIC   = 8'hA5,
    parameter int         TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] wb_addr,
    output logic [31:0] wb_wdata,
    output logic [3:0]  wb_sel,
    output logic        wb_we,
    output logic        wb_cyc,
    output logic        wb_stb,
    input  logic        wb_ack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] entry
);

    typedef enum logic [2:0] {SYNC, HADDR, HCNT, DATA, BUS} state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] cur_addr_q, cur_addr_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] timer_q, timer_d;
    logic        rx_ready_q, rx_ready_d;
    logic [31:0] wb_addr_q, wb_addr_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;
    logic [3:0]  wb_sel_q, wb_sel_d;
    logic        wb_we_q, wb_we_d;
    logic        wb_cyc_q, wb_cyc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [31:0] entry_q, entry_d;

    logic        consume;
    logic [15:0] cnt_full;

    assign consume  = rx_valid && rx_ready_q;
    // Count value as it will look once the current (high) count byte lands.
    assign cnt_full = {rx_data, cnt_q[15:8]};

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        rx_ready_d  = rx_ready_q;
        wb_addr_d   = wb_addr_q;
        wb_wdata_d  = wb_wdata_q;
        wb_sel_d    = wb_sel_q;
        wb_we_d     = wb_we_q;
        wb_cyc_d    = wb_cyc_q;
        entry_d     = entry_q;
        done_d      = 1'b0;
        error_d     = 1'b0;

        case (state_q)
            SYNC: begin
                if (consume && rx_data == MAGIC) begin
                    state_d    = HADDR;
                    byte_cnt_d = 2'd0;
                end
            end
            HADDR: begin
                if (consume) begin
                    // Little-endian: each new byte enters at the top and slides down.
                    addr_d     = {rx_data, addr_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        addr_d[1:0] = 2'b00;
                        byte_cnt_d  = 2'd0;
                        state_d     = HCNT;
                    end
                end
            end
            HCNT: begin
                if (consume) begin
                    cnt_d      = cnt_full;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd1) begin
                        byte_cnt_d = 2'd0;
                        if (cnt_full == 16'd0) begin
                            done_d  = 1'b1;
                            entry_d = addr_q;
                            state_d = SYNC;
                        end else begin
                            remaining_d = cnt_full;
                            cur_addr_d  = addr_q;
                            state_d     = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (consume) begin
                    shift_d    = {rx_data, shift_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        wb_cyc_d   = 1'b1;
                        wb_we_d    = 1'b1;
                        wb_sel_d   = 4'hF;
                        wb_addr_d  = cur_addr_q;
                        wb_wdata_d = shift_d;
                        rx_ready_d = 1'b0;
                        timer_d    = 16'd0;
                        state_d    = BUS;
                    end
                end
            end
            BUS: begin
                // Ack wins over timeout when both land on the same edge.
                if (wb_ack) begin
                    wb_cyc_d    = 1'b0;
                    wb_we_d     = 1'b0;
                    wb_sel_d    = 4'h0;
                    cur_addr_d  = cur_addr_q + 32'd4;
                    remaining_d = remaining_q - 16'd1;
                    timer_d     = 16'd0;
                    rx_ready_d  = 1'b1;
                    if (remaining_q == 16'd1) begin
                        done_d  = 1'b1;
                        entry_d = addr_q;
                        state_d = SYNC;
                    end else begin
                        state_d = DATA;
                    end
                end else if (timer_q == 16'(TIMEOUT - 1)) begin
                    wb_cyc_d   = 1'b0;
                    wb_we_d    = 1'b0;
                    wb_sel_d   = 4'h0;
                    timer_d    = 16'd0;
                    rx_ready_d = 1'b1;
                    error_d    = 1'b1;
                    state_d    = SYNC;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                state_d    = SYNC;
                rx_ready_d = 1'b1;
                wb_cyc_d   = 1'b0;
                wb_we_d    = 1'b0;
                wb_sel_d   = 4'h0;
            end
        endcase

        busy_d = (state_d != SYNC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SYNC;
            byte_cnt_q  <= 2'd0;
            addr_q      <= 32'd0;
            cnt_q       <= 16'd0;
            shift_q     <= 32'd0;
            cur_addr_q  <= 32'd0;
            remaining_q <= 16'd0;
            timer_q     <= 16'd0;
            rx_ready_q  <= 1'b1;
            wb_addr_q   <= 32'd0;
            wb_wdata_q  <= 32'd0;
            wb_sel_q    <= 4'h0;
            wb_we_q     <= 1'b0;
            wb_cyc_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            entry_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            rx_ready_q  <= rx_ready_d;
            wb_addr_q   <= wb_addr_d;
            wb_wdata_q  <= wb_wdata_d;
            wb_sel_q    <= wb_sel_d;
            wb_we_q     <= wb_we_d;
            wb_cyc_q    <= wb_cyc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            entry_q     <= entry_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign wb_addr  = wb_addr_q;
    assign wb_wdata = wb_wdata_q;
    assign wb_sel   = wb_sel_q;
    assign wb_we    = wb_we_q;
    assign wb_cyc   = wb_cyc_q;
    assign wb_stb   = wb_cyc_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign entry    = entry_q;

endmodule

// File: tb/tb_wb_uart_loader.sv
module tb_wb_uart_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] wb_addr, wb_wdata;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb;
    logic        wb_ack = 1'b0;
    logic        busy, done, error;
    logic [31:0] entry;

    int n_cmp = 0;
    int n_fail = 0;

    wb_uart_loader #(.MAGIC(8'hA5), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_sel(wb_sel),
        .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_ack(wb_ack),
        .busy(busy), .done(done), .error(error), .entry(entry)
    );

    always #5 clk = ~clk;

    // Responder and bus monitor, evaluated on the falling edge.
    int          ack_lat = 1;
    int          cyc_len = 0;
    int          last_cyc_len = 0;
    int          n_done = 0;
    int          n_err = 0;
    int          n_both = 0;
    int          rdy_in_bus = 0;
    int          bad_sel = 0;
    logic        done_busy = 1'b0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    always @(negedge clk) begin
        if (wb_cyc && wb_stb) begin
            cyc_len++;
            wb_ack = (cyc_len == ack_lat + 1);
            if (wb_sel !== 4'hF || wb_we !== 1'b1) bad_sel++;
            if (rx_ready) rdy_in_bus++;
            if (wb_ack) begin
                wa.push_back(wb_addr);
                wd.push_back(wb_wdata);
            end
        end else begin
            if (cyc_len != 0) last_cyc_len = cyc_len;
            cyc_len = 0;
            wb_ack  = 1'b0;
        end
        if (done) begin
            n_done++;
            done_busy = busy;
        end
        if (error) n_err++;
        if (done && error) n_both++;
    end

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        n_done = 0;
        n_err = 0;
        n_both = 0;
        rdy_in_bus = 0;
        bad_sel = 0;
        last_cyc_len = 0;
        done_busy = 1'b1;
    endtask

    // Offers one byte and returns just after the edge that consumed it; rx_valid stays high.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_byte: rx_ready stuck low, got %b want 1", rx_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic send_hdr(input logic [31:0] a, input logic [15:0] c);
        send_byte(8'hA5);
        send_word(a);
        send_byte(c[7:0]);
        send_byte(c[15:8]);
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        @(negedge clk);
        while ((busy || wb_cyc) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s idle: busy=%b cyc=%b still set, want 0", name, busy, wb_cyc);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset rx_ready: got %b want 1", rx_ready); end
        n_cmp++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_we !== 1'b0) begin n_fail++; $display("FAIL reset cyc/stb/we: got %b%b%b want 000", wb_cyc, wb_stb, wb_we); end
        n_cmp++; if (wb_sel !== 4'h0) begin n_fail++; $display("FAIL reset sel: got %h want 0", wb_sel); end
        n_cmp++; if (wb_addr !== 32'h0 || wb_wdata !== 32'h0) begin n_fail++; $display("FAIL reset addr/wdata: got %h/%h want 0/0", wb_addr, wb_wdata); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL reset status: got busy=%b done=%b err=%b want 000", busy, done, error); end
        n_cmp++; if (entry !== 32'h0) begin n_fail++; $display("FAIL reset entry: got %h want 0", entry); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        clear_mon();
        ack_lat = 1;
        send_hdr(32'h0000_1000, 16'd2);
        send_word(32'h4433_2211);
        send_word(32'h8877_6655);
        rx_valid = 1'b0;
        wait_idle("basic");
        n_cmp++; if (wa.size() !== 2) begin n_fail++; $display("FAIL basic nwrites: got %0d want 2", wa.size()); end
        else begin
            n_cmp++; if (wa[0] !== 32'h0000_1000 || wd[0] !== 32'h4433_2211) begin n_fail++; $display("FAIL basic w0: got %h@%h want 44332211@00001000", wd[0], wa[0]); end
            n_cmp++; if (wa[1] !== 32'h0000_1004 || wd[1] !== 32'h8877_6655) begin n_fail++; $display("FAIL basic w1: got %h@%h want 88776655@00001004", wd[1], wa[1]); end
        end
        n_cmp++; if (n_done !== 1 || n_err !== 0) begin n_fail++; $display("FAIL basic pulses: got done=%0d err=%0d want 1/0", n_done, n_err); end
        n_cmp++; if (entry !== 32'h0000_1000) begin n_fail++; $display("FAIL basic entry: got %h want 00001000", entry); end
        n_cmp++; if (done_busy !== 1'b0) begin n_fail++; $display("FAIL basic busy_at_done: got %b want 0", done_busy); end
        n_cmp++; if (last_cyc_len !== 2) begin n_fail++; $display("FAIL basic cyc_len: got %0d want 2", last_cyc_len); end
        n_cmp++; if (bad_sel !== 0) begin n_fail++; $display("FAIL basic sel/we during cyc: got %0d bad cycles want 0", bad_sel); end
    endtask

    task automatic test_sync_filter();
        clear_mon();
        ack_lat = 1;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || wb_cyc !== 1'b0) begin n_fail++; $display("FAIL sync junk: got busy=%b cyc=%b want 0/0", busy, wb_cyc); end
        send_hdr(32'h0000_0020, 16'd1);
        send_word(32'hA5A5_00A5);
        rx_valid = 1'b0;
        wait_idle("sync");
        n_cmp++; if (wa.size() !== 1) begin n_fail++; $display("FAIL sync nwrites: got %0d want 1", wa.size()); end
        else begin
            n_cmp++; if (wa[0] !== 32'h0000_0020 || wd[0] !== 32'hA5A5_00A5) begin n_fail++; $display("FAIL sync w0: got %h@%h want a5a500a5@00000020", wd[0], wa[0]); end
        end
        n_cmp++; if (entry !== 32'h0000_0020) begin n_fail++; $display("FAIL sync entry: got %h want 00000020", entry); end
    endtask

    task automatic test_zero_count();
        clear_mon();
        send_hdr(32'h0000_0003, 16'd0);
        rx_valid = 1'b0;
        wait_idle("zero");
        n_cmp++; if (wa.size() !== 0 || last_cyc_len !== 0) begin n_fail++; $display("FAIL zero bus activity: got %0d writes, cyc_len %0d want 0/0", wa.size(), last_cyc_len); end
        n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL zero done: got %0d want 1", n_done); end
        n_cmp++; if (entry !== 32'h0000_0000) begin n_fail++; $display("FAIL zero entry: got %h want 00000000", entry); end
    endtask

    task automatic test_backpressure();
        clear_mon();
        ack_lat = 5;
        send_hdr(32'h0000_0200, 16'd2);
        send_word(32'hDEAD_BEEF);
        send_word(32'h0123_4567);
        rx_valid = 1'b0;
        wait_idle("bp");
        n_cmp++; if (rdy_in_bus !== 0) begin n_fail++; $display("FAIL bp rx_ready in bus: got %0d cycles want 0", rdy_in_bus); end
        n_cmp++; if (last_cyc_len !== 6) begin n_fail++; $display("FAIL bp cyc_len: got %0d want 6", last_cyc_len); end
        n_cmp++; if (wa.size() !== 2) begin n_fail++; $display("FAIL bp nwrites: got %0d want 2", wa.size()); end
        else begin
            n_cmp++; if (wd[0] !== 32'hDEAD_BEEF || wa[0] !== 32'h0000_0200) begin n_fail++; $display("FAIL bp w0: got %h@%h want deadbeef@00000200", wd[0], wa[0]); end
            n_cmp++; if (wd[1] !== 32'h0123_4567 || wa[1] !== 32'h0000_0204) begin n_fail++; $display("FAIL bp w1: got %h@%h want 01234567@00000204", wd[1], wa[1]); end
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        ack_lat = 1000;
        send_hdr(32'h0000_0040, 16'd1);
        send_word(32'h1111_2222);
        rx_valid = 1'b0;
        wait_idle("timeout");
        n_cmp++; if (last_cyc_len !== 16) begin n_fail++; $display("FAIL timeout cyc_len: got %0d want 16", last_cyc_len); end
        n_cmp++; if (n_err !== 1 || n_done !== 0 || n_both !== 0) begin n_fail++; $display("FAIL timeout pulses: got err=%0d done=%0d both=%0d want 1/0/0", n_err, n_done, n_both); end
        n_cmp++; if (entry !== 32'h0000_0200) begin n_fail++; $display("FAIL timeout entry: got %h want 00000200", entry); end
        clear_mon();
        ack_lat = 1;
        send_hdr(32'h0000_0080, 16'd1);
        send_word(32'hCAFE_F00D);
        rx_valid = 1'b0;
        wait_idle("after_timeout");
        n_cmp++; if (wa.size() !== 1 || n_done !== 1) begin n_fail++; $display("FAIL after_timeout: got %0d writes %0d done want 1/1", wa.size(), n_done); end
        else begin
            n_cmp++; if (wa[0] !== 32'h0000_0080 || wd[0] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL after_timeout w0: got %h@%h want cafef00d@00000080", wd[0], wa[0]); end
        end
    endtask

    task automatic test_wrap_and_reset();
        int guard = 0;
        clear_mon();
        ack_lat = 1;
        send_hdr(32'hFFFF_FFFC, 16'd2);
        send_word(32'hAAAA_0001);
        send_word(32'hBBBB_0002);
        rx_valid = 1'b0;
        wait_idle("wrap");
        n_cmp++; if (wa.size() !== 2) begin n_fail++; $display("FAIL wrap nwrites: got %0d want 2", wa.size()); end
        else begin
            n_cmp++; if (wa[0] !== 32'hFFFF_FFFC || wa[1] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap addrs: got %h,%h want fffffffc,00000000", wa[0], wa[1]); end
        end
        n_cmp++; if (entry !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap entry: got %h want fffffffc", entry); end
        clear_mon();
        ack_lat = 20;
        send_hdr(32'h0000_0300, 16'd1);
        send_word(32'h5555_6666);
        rx_valid = 1'b0;
        @(negedge clk);
        while (!wb_cyc && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++; if (wb_cyc !== 1'b1) begin n_fail++; $display("FAIL rst_bus cyc before reset: got %b want 1", wb_cyc); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin n_fail++; $display("FAIL rst_bus cyc/stb: got %b/%b want 0/0", wb_cyc, wb_stb); end
        n_cmp++; if (busy !== 1'b0 || rx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_bus busy/rdy: got %b/%b want 0/1", busy, rx_ready); end
        n_cmp++; if (entry !== 32'h0) begin n_fail++; $display("FAIL rst_bus entry: got %h want 0", entry); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (wa.size() !== 0 || n_done !== 0) begin n_fail++; $display("FAIL rst_bus writes/done: got %0d/%0d want 0/0", wa.size(), n_done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sync_filter();
        test_zero_count();
        test_backpressure();
        test_timeout();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
